// File: rtl/adc_lvds_emulator.sv
`default_nettype none
// ============================================================================
// adc_lvds_emulator : emits 14-lane x 10-bit deserialised ADC words (zero, ramp,
// square, constant; PRBS12 mode 4 when ADC_EMU_PRBS_EN is defined). Rev 1.0
// ============================================================================
module adc_lvds_emulator (
   input  logic               clklvds,
   input  logic               rstn,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [2:0]         cfg_mode,
   input  logic signed [11:0] cfg_value,
   input  logic [15:0]        cfg_halfperiod,
   input  logic [15:0]        cfg_count,
   input  logic               run,
   output logic [139:0]       lvds1bits,
   output logic               bits_valid,
   output logic [15:0]        wordcount
);

   localparam logic [0:0]         c_st_idle = 1'b0;
   localparam logic [0:0]         c_st_run  = 1'b1;
   localparam logic [9:0]         c_frame   = 10'b0000011111;
   localparam logic signed [11:0] c_pos_max = 12'sd2047;
   localparam logic signed [11:0] c_neg_min = -12'sd2048;

   logic [0:0]         r_state;
   logic               r_done;
   logic [2:0]         r_mode;
   logic signed [11:0] r_value;
   logic [15:0]        r_halfperiod;
   logic [15:0]        r_count;
   logic [11:0]        r_base;
   logic               r_phase;
   logic [15:0]        r_hcnt;
   logic [15:0]        r_wordcount;
   logic [139:0]       r_bits;
   logic               r_valid;

   logic               w_idle;
   logic               w_load;
   logic               w_emit;
   logic               w_end;
   logic [2:0]         w_mode;
   logic signed [11:0] w_value;
   logic signed [11:0] w_value_neg;
   logic [15:0]        w_halfperiod;
   logic [15:0]        w_hp;
   logic [15:0]        w_count;
   logic [15:0]        w_wc_cur;
   logic [15:0]        w_wc_next;
   logic [11:0]        w_base_cur;
   logic               w_phase_cur;
   logic [15:0]        w_hcnt_cur;
   logic [15:0]        w_hcnt_inc;
   logic               w_toggle;
   logic signed [11:0] w_smp [0:9];
   logic [139:0]       w_word;

   assign w_idle    = (r_state == c_st_idle);
   assign cfg_ready = w_idle;
   assign w_load    = cfg_valid && cfg_ready;

   // A load coinciding with RUN entry must already shape the first word.
   assign w_mode       = w_load ? cfg_mode       : r_mode;
   assign w_value      = w_load ? cfg_value      : r_value;
   assign w_halfperiod = w_load ? cfg_halfperiod : r_halfperiod;
   assign w_count      = w_load ? cfg_count      : r_count;

   // r_done holds off a restart until run has been seen low after a burst end.
   assign w_emit    = run && !r_done;
   assign w_wc_cur  = w_idle ? 16'd0 : r_wordcount;
   assign w_wc_next = (w_wc_cur == 16'hFFFF) ? w_wc_cur : w_wc_cur + 16'd1;
   assign w_end     = w_emit && (w_count != 16'd0) && (w_wc_next == w_count);

   assign w_base_cur  = w_idle ? 12'd0 : r_base;
   assign w_phase_cur = w_idle ? 1'b0  : r_phase;
   assign w_hcnt_cur  = w_idle ? 16'd0 : r_hcnt;
   assign w_hp        = (w_halfperiod == 16'd0) ? 16'd1 : w_halfperiod;
   assign w_hcnt_inc  = w_hcnt_cur + 16'd1;
   assign w_toggle    = (w_hcnt_inc >= w_hp);
   assign w_value_neg = (w_value == c_neg_min) ? c_pos_max : -w_value;

`ifdef ADC_EMU_PRBS_EN
   logic [11:0] r_lfsr;
   logic [11:0] w_lfsr_cur;
   logic [11:0] w_prbs [0:9];

   assign w_lfsr_cur = w_idle ? 12'hFFF : r_lfsr;

   always_comb begin
      logic [11:0] w_v;
      w_v = w_lfsr_cur;
      for (int s = 0; s < 10; s++) begin
         w_v       = {w_v[10:0], w_v[11] ^ w_v[5] ^ w_v[3] ^ w_v[0]};
         w_prbs[s] = w_v;
      end
   end

   always_ff @(posedge clklvds or negedge rstn) begin
      if (!rstn) begin
         r_lfsr <= 12'hFFF;
      end else if (w_emit) begin
         r_lfsr <= w_prbs[9];
      end else begin
         r_lfsr <= 12'hFFF;
      end
   end
`endif

   always_comb begin
      for (int s = 0; s < 10; s++) w_smp[s] = '0;
      case (w_mode)
         3'd1: for (int s = 0; s < 10; s++) w_smp[s] = $signed(w_base_cur + 12'(s));
         3'd2: for (int s = 0; s < 10; s++) w_smp[s] = w_phase_cur ? w_value : w_value_neg;
         3'd3: for (int s = 0; s < 10; s++) w_smp[s] = w_value;
`ifdef ADC_EMU_PRBS_EN
         3'd4: for (int s = 0; s < 10; s++) w_smp[s] = $signed(w_prbs[s]);
`endif
         default: ;
      endcase
   end

   // Bit b of sample s lives at 10*b+s; lane 12 flags full-scale samples.
   always_comb begin
      w_word = '0;
      for (int s = 0; s < 10; s++) begin
         for (int b = 0; b < 12; b++) w_word[10*b+s] = w_smp[s][b];
         w_word[120+s] = (w_smp[s] == c_pos_max) || (w_smp[s] == c_neg_min);
      end
      w_word[139:130] = c_frame;
   end

   always_ff @(posedge clklvds or negedge rstn) begin
      if (!rstn) begin
         r_mode       <= 3'd0;
         r_value      <= 12'sd10;
         r_halfperiod <= 16'd1;
         r_count      <= 16'd0;
      end else if (w_load) begin
         r_mode       <= cfg_mode;
         r_value      <= cfg_value;
         r_halfperiod <= cfg_halfperiod;
         r_count      <= cfg_count;
      end
   end

   always_ff @(posedge clklvds or negedge rstn) begin
      if (!rstn) begin
         r_state     <= c_st_idle;
         r_done      <= 1'b0;
         r_base      <= 12'd0;
         r_phase     <= 1'b0;
         r_hcnt      <= 16'd0;
         r_wordcount <= 16'd0;
         r_bits      <= '0;
         r_valid     <= 1'b0;
      end else if (w_emit) begin
         r_state     <= w_end ? c_st_idle : c_st_run;
         r_done      <= w_end;
         r_base      <= w_base_cur + 12'd10;
         r_phase     <= w_toggle ? ~w_phase_cur : w_phase_cur;
         r_hcnt      <= w_toggle ? 16'd0 : w_hcnt_inc;
         r_wordcount <= w_wc_next;
         r_bits      <= w_word;
         r_valid     <= 1'b1;
      end else begin
         r_state     <= c_st_idle;
         r_done      <= r_done && run;
         r_base      <= 12'd0;
         r_phase     <= 1'b0;
         r_hcnt      <= 16'd0;
         r_wordcount <= (r_done && run) ? r_wordcount : 16'd0;
         r_bits      <= '0;
         r_valid     <= 1'b0;
      end
   end

   assign lvds1bits  = r_bits;
   assign bits_valid = r_valid;
   assign wordcount  = r_wordcount;

endmodule
`default_nettype wire

// File: tb/tb_adc_lvds_emulator.sv
`default_nettype none
// ============================================================================
// tb_adc_lvds_emulator : directed checks of adc_lvds_emulator. Rev 1.0
// ============================================================================
module tb_adc_lvds_emulator;

   logic               clklvds = 1'b0;
   logic               rstn;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [2:0]         cfg_mode;
   logic signed [11:0] cfg_value;
   logic [15:0]        cfg_halfperiod;
   logic [15:0]        cfg_count;
   logic               run;
   logic [139:0]       lvds1bits;
   logic               bits_valid;
   logic [15:0]        wordcount;

   int total = 0;
   int bad   = 0;
   logic [139:0] frame_word;

   adc_lvds_emulator dut (
      .clklvds        (clklvds),
      .rstn           (rstn),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_mode       (cfg_mode),
      .cfg_value      (cfg_value),
      .cfg_halfperiod (cfg_halfperiod),
      .cfg_count      (cfg_count),
      .run            (run),
      .lvds1bits      (lvds1bits),
      .bits_valid     (bits_valid),
      .wordcount      (wordcount)
   );

   always #5 clklvds = ~clklvds;

   task automatic tick();
      @(posedge clklvds);
      #1;
   endtask

   task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] smp(input logic [139:0] w, input int s);
      logic [11:0] r;
      for (int b = 0; b < 12; b++) r[b] = w[10*b+s];
      return r;
   endfunction

   function automatic logic [9:0] lane(input logic [139:0] w, input int l);
      return w[10*l +: 10];
   endfunction

   task automatic load(input logic [2:0] m, input logic signed [11:0] v,
                       input logic [15:0] hp, input logic [15:0] cnt);
      cfg_mode       = m;
      cfg_value      = v;
      cfg_halfperiod = hp;
      cfg_count      = cnt;
      cfg_valid      = 1'b1;
      tick();
      cfg_valid      = 1'b0;
   endtask

   initial begin
      frame_word          = '0;
      frame_word[139:130] = 10'b0000011111;
      rstn = 1'b0; run = 1'b0; cfg_valid = 1'b0;
      cfg_mode = 3'd0; cfg_value = 12'sd0; cfg_halfperiod = 16'd0; cfg_count = 16'd0;
      tick(); tick();
      chk("rst_bits",  lvds1bits, 140'd0);
      chk("rst_valid", bits_valid, 1'b0);
      chk("rst_wc",    wordcount, 16'd0);
      chk("rst_ready", cfg_ready, 1'b1);
      rstn = 1'b1;
      tick();

      // Default config: mode 0, continuous
      run = 1'b1;
      tick();
      chk("def_valid", bits_valid, 1'b1);
      chk("def_word",  lvds1bits, frame_word);
      chk("def_wc1",   wordcount, 16'd1);
      chk("def_ready", cfg_ready, 1'b0);
      tick();
      chk("def_wc2",   wordcount, 16'd2);
      run = 1'b0;
      tick();
      chk("stop_valid", bits_valid, 1'b0);
      chk("stop_bits",  lvds1bits, 140'd0);
      chk("stop_wc",    wordcount, 16'd0);
      chk("stop_ready", cfg_ready, 1'b1);

      // Ramp burst of 3
      load(3'd1, 12'sd0, 16'd1, 16'd3);
      run = 1'b1;
      tick();
      chk("r0_s0", smp(lvds1bits, 0), 12'd0);
      chk("r0_s9", smp(lvds1bits, 9), 12'd9);
      chk("r0_l12", lane(lvds1bits, 12), 10'h000);
      chk("r0_l13", lane(lvds1bits, 13), 10'b0000011111);
      tick();
      chk("r1_s0", smp(lvds1bits, 0), 12'd10);
      chk("r1_s9", smp(lvds1bits, 9), 12'd19);
      tick();
      chk("r2_s0", smp(lvds1bits, 0), 12'd20);
      chk("r2_s9", smp(lvds1bits, 9), 12'd29);
      chk("r2_valid", bits_valid, 1'b1);
      chk("r2_wc", wordcount, 16'd3);
      tick();
      chk("rend_valid", bits_valid, 1'b0);
      chk("rend_bits",  lvds1bits, 140'd0);
      chk("rend_wc",    wordcount, 16'd3);
      tick();
      chk("rhold_valid", bits_valid, 1'b0);
      run = 1'b0;
      tick();
      run = 1'b1;
      tick();
      chk("rre_s0", smp(lvds1bits, 0), 12'd0);
      chk("rre_wc", wordcount, 16'd1);
      run = 1'b0;
      tick();

      // run drops exactly where the burst would end
      load(3'd1, 12'sd0, 16'd1, 16'd2);
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      chk("co_valid", bits_valid, 1'b0);
      tick();
      chk("co_valid2", bits_valid, 1'b0);

      // Square +/-100, half-period 2
      load(3'd2, 12'sd100, 16'd2, 16'd0);
      run = 1'b1;
      tick(); chk("sq0", smp(lvds1bits, 0), 12'hF9C);
      chk("sq0_s9", smp(lvds1bits, 9), 12'hF9C);
      tick(); chk("sq1", smp(lvds1bits, 0), 12'hF9C);
      tick(); chk("sq2", smp(lvds1bits, 0), 12'h064);
      tick(); chk("sq3", smp(lvds1bits, 0), 12'h064);
      tick(); chk("sq4", smp(lvds1bits, 0), 12'hF9C);
      chk("sq_l12", lane(lvds1bits, 12), 10'h000);
      run = 1'b0;
      tick();

      // Half-period 0 behaves as 1
      load(3'd2, 12'sd5, 16'd0, 16'd0);
      run = 1'b1;
      tick(); chk("hp0_w0", smp(lvds1bits, 0), 12'hFFB);
      tick(); chk("hp0_w1", smp(lvds1bits, 0), 12'h005);
      run = 1'b0;
      tick();

      // Full-scale flags
      load(3'd3, -12'sd2048, 16'd1, 16'd0);
      run = 1'b1;
      tick();
      chk("c_s0",  smp(lvds1bits, 0), 12'h800);
      chk("c_l12", lane(lvds1bits, 12), 10'h3FF);
      chk("c_l13", lane(lvds1bits, 13), 10'b0000011111);
      run = 1'b0;
      tick();
      load(3'd2, -12'sd2048, 16'd1, 16'd0);
      run = 1'b1;
      tick();
      chk("sat_s0",  smp(lvds1bits, 0), 12'h7FF);
      chk("sat_l12", lane(lvds1bits, 12), 10'h3FF);
      tick();
      chk("sat1_s0",  smp(lvds1bits, 0), 12'h800);
      chk("sat1_l12", lane(lvds1bits, 12), 10'h3FF);
      run = 1'b0;
      tick();

      // Config held off during RUN
      load(3'd3, 12'sd7, 16'd1, 16'd0);
      run = 1'b1;
      tick();
      chk("hold_s0", smp(lvds1bits, 0), 12'd7);
      cfg_mode = 3'd3; cfg_value = 12'sd99; cfg_valid = 1'b1;
      #1;
      chk("hold_ready", cfg_ready, 1'b0);
      tick();
      cfg_valid = 1'b0;
      chk("hold_s0b", smp(lvds1bits, 0), 12'd7);
      run = 1'b0;
      tick();
      chk("hold_ready1", cfg_ready, 1'b1);
      run = 1'b1;
      tick();
      chk("hold_keep", smp(lvds1bits, 0), 12'd7);
      run = 1'b0;
      tick();
      load(3'd3, 12'sd55, 16'd1, 16'd0);
      run = 1'b1;
      tick();
      chk("load_new", smp(lvds1bits, 0), 12'h037);
      run = 1'b0;
      tick();

      // Other modes read as zero
      load(3'd5, 12'sd300, 16'd1, 16'd0);
      run = 1'b1;
      tick();
      chk("m5_word", lvds1bits, frame_word);
      run = 1'b0;
      tick();
      load(3'd4, 12'sd300, 16'd1, 16'd0);
      run = 1'b1;
      tick();
`ifdef ADC_EMU_PRBS_EN
      chk("m4_s0", smp(lvds1bits, 0), 12'hFFE);
`else
      chk("m4_word", lvds1bits, frame_word);
`endif
      run = 1'b0;
      tick();

      // Long ramp: full-scale crossing and wrap
      load(3'd1, 12'sd0, 16'd1, 16'd0);
      run = 1'b1;
      for (int i = 0; i < 205; i++) tick();
      chk("rl_s0_204", smp(lvds1bits, 0), 12'd2040);
      chk("rl_l12",    lane(lvds1bits, 12), 10'h180);
      for (int i = 0; i < 205; i++) tick();
      chk("rl_s0_409", smp(lvds1bits, 0), 12'd4090);
      chk("rl_s9_409", smp(lvds1bits, 9), 12'd3);
      chk("rl_wc",     wordcount, 16'd410);
      run = 1'b0;
      tick();

      // Reset mid-burst
      load(3'd1, 12'sd0, 16'd1, 16'd0);
      run = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("mb_s0", smp(lvds1bits, 0), 12'd40);
      #2 rstn = 1'b0;
      #1;
      chk("mb_bits",  lvds1bits, 140'd0);
      chk("mb_valid", bits_valid, 1'b0);
      chk("mb_wc",    wordcount, 16'd0);
      chk("mb_ready", cfg_ready, 1'b1);
      tick();
      rstn = 1'b1;
      tick();
      chk("mb_def", lvds1bits, frame_word);
      run = 1'b0;
      tick();
      load(3'd1, 12'sd0, 16'd1, 16'd0);
      run = 1'b1;
      tick();
      chk("mb_re_s0", smp(lvds1bits, 0), 12'd0);
      chk("mb_re_s1", smp(lvds1bits, 1), 12'd1);
      chk("mb_re_wc", wordcount, 16'd1);
      run = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adc_lvds_emulator.md
ADC_LVDS_EMULATOR -- requirements
Module: adc_lvds_emulator

Interface
REQ-001 SHALL have ports: clklvds in 1, LVDS half-bit-rate clock; rstn in 1, asynchronous active-low reset (reset rstn, asynchronous, active-low; clock clklvds).
REQ-002 SHALL have: cfg_valid in 1, config strobe; cfg_ready out 1, high only in IDLE; cfg_mode in 3, pattern select; cfg_value in 12 signed, fixed value or square amplitude; cfg_halfperiod in 16, square half-period in words; cfg_count in 16, burst length in words, 0 = continuous.
REQ-003 SHALL have: run in 1, level-sensitive enable; lvds1bits out 140, emulated deserialised word; bits_valid out 1, word qualifier; wordcount out 16, words emitted in current burst.

Function
REQ-004 SHALL pack lvds1bits as 14 lanes x 10 bits; sample s (0..9), bit b (0..11) at lvds1bits[10*b+s], so sample 0 = bits {110,100,...,10,0}.
REQ-005 SHALL drive lane 12 (bits 120..129) bit s = 1 when sample s equals +2047 or -2048, else 0.
REQ-006 SHALL drive lane 13 (bits 130..139) with the constant frame pattern 10'b0000011111 whenever bits_valid=1, else 0.
REQ-007 SHALL implement states IDLE and RUN; IDLE->RUN when run=1; RUN->IDLE when run=0 or when cfg_count!=0 and wordcount reaches cfg_count.
REQ-008 SHALL accept config only on cfg_valid && cfg_ready; registered values take effect from the next RUN entry; cfg_valid in RUN is held off (cfg_ready=0).
REQ-009 SHALL emit one registered word per clklvds cycle in RUN with bits_valid=1; first valid word appears the cycle after run is sampled high (1-cycle latency).
REQ-010 SHALL, in IDLE, drive lvds1bits=0, bits_valid=0, and clear wordcount and pattern state (ramp base, square phase, half-period counter).
REQ-011 Mode 0 (zero): all 10 samples = 0.
REQ-012 Mode 1 (ramp): sample s = base+s modulo 4096 (two's complement 12-bit wrap); base starts 0, advances by 10 per word.
REQ-013 Mode 2 (square): all samples of a word = -cfg_value in phase 0, +cfg_value in phase 1; phase starts 0, toggles after every cfg_halfperiod words; cfg_halfperiod=0 treated as 1.
REQ-014 Square negation SHALL saturate: -(-2048) yields +2047.
REQ-015 Mode 3 (constant): all samples = cfg_value.
REQ-016 Modes 5..7, and mode 4 when the macro is absent, SHALL behave as mode 0.
REQ-017 wordcount SHALL increment per valid word, saturate at 16'hFFFF in continuous mode, and end the burst after exactly cfg_count valid words.
REQ-018 If burst end and run=0 coincide, SHALL go to IDLE once; neither SHALL emit an extra word.
REQ-019 run re-asserted while in IDLE after burst end SHALL start a fresh burst from cleared pattern state.

Reset
REQ-020 On rstn low, SHALL immediately set state IDLE, lvds1bits=0, bits_valid=0, wordcount=0, cfg_ready=1.
REQ-021 Reset SHALL restore config to mode 0, value 12'sd10, halfperiod 1, count 0.
REQ-022 Reset asserted mid-burst SHALL abort with no partial word; first word after release follows REQ-009 timing.

Configuration
REQ-023 Macro ADC_EMU_PRBS_EN, when defined, SHALL add mode 4: PRBS12 LFSR (x^12+x^6+x^4+x+1, seed 12'hFFF at RUN entry), advanced once per sample, ten steps per word, sample = LFSR state.
REQ-024 Without ADC_EMU_PRBS_EN no LFSR logic SHALL be synthesised and mode 4 SHALL output zeros.

Verification
REQ-025 Mode 1, count 3, run high -> three words: sample0 = 0, 10, 20; sample9 = 9, 19, 29; then bits_valid=0, wordcount=3.
REQ-026 Mode 2, value 100, halfperiod 2, count 0 -> samples -100,-100,+100,+100,-100...; sample 0 readable at bits {110..0} as 12'hF9C then 12'h064.
REQ-027 Mode 3, value -2048 -> lane 12 = 10'h3FF, lane 13 = 10'b0000011111; mode 2 value -2048 -> +2047 phase also flags overrange.
REQ-028 cfg_valid pulsed during RUN -> cfg_ready=0, config unchanged; after run drops, cfg_ready=1 and load succeeds.
REQ-029 rstn pulsed low mid-burst (mode 1, word 5) -> outputs zero same cycle; restart yields base 0.
REQ-030 With ADC_EMU_PRBS_EN, mode 4 -> first sample = LFSR after one step from 12'hFFF, sequence period 4095; without macro -> all zeros.
